// File: rtl/uart_pkg.sv
// UART shared definitions: transmitter state encoding and line levels.
// Imported by the TX block (and later the RX side).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        GAP
    } uart_tx_state_t;

    localparam int   UART_DATA_BITS   = 8;
    localparam logic UART_START_LEVEL = 1'b0;
    localparam logic UART_IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/axis_interface.sv
// 8-bit AXI-Stream bundle: tdata/tvalid/tready/tlast.
// Modports: Source drives data, Sink returns tready.
interface axis_interface;

    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;

    modport Source (
        input  tready,
        output tdata,
        output tvalid,
        output tlast
    );

    modport Sink (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/uart_bit_timer.sv
// Baud counter: counts 0..CLKS_PER_BIT-1, flags the last cycle of a bit.
// Ports: clk, reset (async low), clear (hold at 0), bit_end (out).
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_end
);

    localparam int W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] r_cnt;

    assign bit_end = (r_cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (clear || bit_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/axis_uart_tx.sv
// UART transmitter (8N1/8N2, LSB first) fed by an AXI-Stream byte sink.
// Ports: clk, reset (async low), encoded_stream (Sink), tx, busy, frame_done.
module axis_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 868,
    parameter int STOP_BITS      = 1,
    parameter int FRAME_GAP_BITS = 0
) (
    input  logic          clk,
    input  logic          reset,
    axis_interface.Sink   encoded_stream,
    output logic          tx,
    output logic          busy,
    output logic          frame_done
);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("axis_uart_tx: CLKS_PER_BIT must be >= 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("axis_uart_tx: STOP_BITS must be 1 or 2");
    end

    localparam int SW = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;
    localparam int GW = (FRAME_GAP_BITS > 1) ? $clog2(FRAME_GAP_BITS) : 1;

    localparam logic [SW-1:0] STOP_LAST =
        SW'((STOP_BITS > 0) ? STOP_BITS - 1 : 0);
    localparam logic [GW-1:0] GAP_LAST =
        GW'((FRAME_GAP_BITS > 0) ? FRAME_GAP_BITS - 1 : 0);
    localparam logic [2:0] BIT_LAST = 3'(UART_DATA_BITS - 1);
    localparam logic HAS_GAP = (FRAME_GAP_BITS > 0);

    uart_tx_state_t              r_state;
    logic [UART_DATA_BITS-1:0]   r_shift;
    logic                        r_last;
    logic [2:0]                  r_bit_idx;
    logic [SW-1:0]               r_stop_cnt;
    logic [GW-1:0]               r_gap_cnt;
    logic                        r_tx;
    logic                        r_tready;
    logic                        r_frame_done;

    logic w_bit_end;
    logic w_clear;

    // Every non-IDLE transition happens on bit_end, where the timer
    // wraps to 0 anyway, so holding it clear in IDLE is enough to
    // start each state with a fresh count.
    assign w_clear = (r_state == IDLE);

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_clear),
        .bit_end(w_bit_end)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_last       <= 1'b0;
            r_bit_idx    <= '0;
            r_stop_cnt   <= '0;
            r_gap_cnt    <= '0;
            r_tx         <= UART_IDLE_LEVEL;
            r_tready     <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (r_tready && encoded_stream.tvalid) begin
                        r_shift  <= encoded_stream.tdata;
                        r_last   <= encoded_stream.tlast;
                        r_tready <= 1'b0;
                        r_tx     <= UART_START_LEVEL;
                        r_state  <= START;
                    end else begin
                        r_tready <= 1'b1;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= DATA;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_shift <= r_shift >> 1;
                        if (r_bit_idx == BIT_LAST) begin
                            r_stop_cnt <= '0;
                            r_tx       <= UART_IDLE_LEVEL;
                            r_state    <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_tx      <= r_shift[1];
                        end
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        if (r_stop_cnt == STOP_LAST) begin
                            if (r_last && HAS_GAP) begin
                                r_gap_cnt <= '0;
                                r_state   <= GAP;
                            end else begin
                                r_tready     <= 1'b1;
                                r_frame_done <= r_last;
                                r_state      <= IDLE;
                            end
                        end else begin
                            r_stop_cnt <= r_stop_cnt + 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (w_bit_end) begin
                        if (r_gap_cnt == GAP_LAST) begin
                            r_tready     <= 1'b1;
                            r_frame_done <= 1'b1;
                            r_state      <= IDLE;
                        end else begin
                            r_gap_cnt <= r_gap_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign encoded_stream.tready = r_tready;
    assign tx         = r_tx;
    assign busy       = (r_state != IDLE);
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_axis_uart_tx.sv
// Bench for axis_uart_tx: scoreboard-decoded line plus directed timing checks.
// Three instances cover the default, 2-stop/gap and full-baud configurations.
module tb_axis_uart_tx;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_bc = 1'b1;
    logic tx_a, busy_a, fd_a;
    logic tx_b, busy_b, fd_b;
    logic tx_c, busy_c, fd_c;

    axis_interface ifa ();
    axis_interface ifb ();
    axis_interface ifc ();

    axis_uart_tx #(
        .CLKS_PER_BIT(4), .STOP_BITS(1), .FRAME_GAP_BITS(0)
    ) u_a (
        .clk(clk), .reset(rst_a), .encoded_stream(ifa),
        .tx(tx_a), .busy(busy_a), .frame_done(fd_a)
    );

    axis_uart_tx #(
        .CLKS_PER_BIT(4), .STOP_BITS(2), .FRAME_GAP_BITS(3)
    ) u_b (
        .clk(clk), .reset(rst_bc), .encoded_stream(ifb),
        .tx(tx_b), .busy(busy_b), .frame_done(fd_b)
    );

    axis_uart_tx #(
        .CLKS_PER_BIT(868), .STOP_BITS(1), .FRAME_GAP_BITS(0)
    ) u_c (
        .clk(clk), .reset(rst_bc), .encoded_stream(ifc),
        .tx(tx_c), .busy(busy_c), .frame_done(fd_c)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] q_a[$];
    int starts_a[$];
    int fd_cnt_a = 0;
    int fd_cyc_a = -1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (fd_a === 1'b1) begin
            fd_cnt_a++;
            fd_cyc_a = cyc;
        end
    end

    // Line monitor for instance A: decodes each frame at mid-bit and
    // checks it against the expected-byte queue.
    initial begin : mon_a
        logic prev;
        logic ok;
        logic stp;
        logic [7:0] b;
        int st;
        int ex;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_a && prev === 1'b1 && tx_a === 1'b0) begin
                st = cyc;
                ok = 1'b1;
                b = '0;
                stp = 1'b0;
                for (int n = 1; n <= 38; n++) begin
                    @(negedge clk);
                    if (!rst_a) begin
                        ok = 1'b0;
                        break;
                    end
                    if (n >= 6 && n <= 34 && (n % 4) == 2)
                        b[(n - 6) / 4] = tx_a;
                    if (n == 38) stp = tx_a;
                end
                if (ok) begin
                    if (q_a.size() == 0) begin
                        chk("unexpected_byte", int'(b), -1);
                    end else begin
                        ex = int'(q_a.pop_front());
                        chk("rx_byte", int'(b), ex);
                        chk("stop_bit", int'(stp), 1);
                        starts_a.push_back(st);
                    end
                end
            end
            prev = tx_a;
        end
    end

    task automatic send_a(input logic [7:0] d, input logic l,
                          output int c0);
        int k;
        ifa.tdata = d;
        ifa.tlast = l;
        ifa.tvalid = 1'b1;
        for (k = 0; k < 200 && ifa.tready !== 1'b1; k++) @(negedge clk);
        if (k == 200) chk("send_a_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        c0 = cyc;
    endtask

    initial begin : main
        int c0, c1, c2, f0, ns, bad, bz, rdy, viol, k;
        int lo, hi, fdc, nst, lvl, len;
        logic seen;
        logic [9:0] e1;
        int runs[$];
        int exp6[5];

        e1 = {1'b1, 8'h55, 1'b0};
        exp6 = '{1736, 868, 868, 868, 3472};
        ifa.tvalid = 1'b0; ifa.tdata = '0; ifa.tlast = 1'b0;
        ifb.tvalid = 1'b0; ifb.tdata = '0; ifb.tlast = 1'b0;
        ifc.tvalid = 1'b0; ifc.tdata = '0; ifc.tlast = 1'b0;

        #1;
        rst_a = 1'b0;
        rst_bc = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", int'(tx_a), 1);
        chk("rst_tready", int'(ifa.tready), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_frame_done", int'(fd_a), 0);
        rst_a = 1'b1;
        rst_bc = 1'b1;
        @(negedge clk);

        // 1) single 0x55
        f0 = fd_cnt_a;
        q_a.push_back(8'h55);
        send_a(8'h55, 1'b0, c0);
        ifa.tvalid = 1'b0;
        bad = 0; bz = 0; rdy = 0;
        for (int j = 0; j < 40; j++) begin
            if (j > 0) @(negedge clk);
            if (tx_a !== e1[j / 4]) bad++;
            if (busy_a === 1'b1) bz++;
            if (ifa.tready === 1'b1) rdy++;
        end
        chk("t1_tx_bad_samples", bad, 0);
        chk("t1_busy_cycles", bz, 40);
        chk("t1_tready_high_cycles", rdy, 0);
        @(negedge clk);
        chk("t1_busy_after", int'(busy_a), 0);
        chk("t1_tready_after", int'(ifa.tready), 1);
        chk("t1_no_frame_done", fd_cnt_a - f0, 0);

        // 2) back-to-back 0x11, 0x22, 0x00(last)
        ns = starts_a.size();
        f0 = fd_cnt_a;
        q_a.push_back(8'h11);
        q_a.push_back(8'h22);
        q_a.push_back(8'h00);
        send_a(8'h11, 1'b0, c0);
        send_a(8'h22, 1'b0, c1);
        send_a(8'h00, 1'b1, c2);
        ifa.tvalid = 1'b0;
        ifa.tlast = 1'b0;
        repeat (45) @(negedge clk);
        chk("t2_bytes_seen", starts_a.size() - ns, 3);
        if (starts_a.size() == ns + 3) begin
            chk("t2_spacing_1", starts_a[ns + 1] - starts_a[ns], 41);
            chk("t2_spacing_2", starts_a[ns + 2] - starts_a[ns + 1], 41);
            chk("t2_fd_cycle", fd_cyc_a, starts_a[ns + 2] + 40);
        end
        chk("t2_fd_count", fd_cnt_a - f0, 1);

        // 3) stall with 0xA5 held while busy
        q_a.push_back(8'h3E);
        q_a.push_back(8'hA5);
        send_a(8'h3E, 1'b0, c0);
        ifa.tdata = 8'hA5;
        viol = 0;
        for (k = 0; k < 100; k++) begin
            if (busy_a === 1'b1 && ifa.tready === 1'b1) viol++;
            if (ifa.tready === 1'b1) break;
            @(negedge clk);
        end
        if (k == 100) chk("t3_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        c1 = cyc;
        ifa.tvalid = 1'b0;
        chk("t3_tready_while_busy", viol, 0);
        chk("t3_held_start_gap", c1 - c0, 41);
        repeat (45) @(negedge clk);

        // 5) reset mid-DATA bit 3, then 0x3C
        send_a(8'hC3, 1'b0, c0);
        ifa.tvalid = 1'b0;
        repeat (17) @(negedge clk);
        #2 rst_a = 1'b0;
        #1;
        chk("t5_rst_tx", int'(tx_a), 1);
        chk("t5_rst_tready", int'(ifa.tready), 0);
        chk("t5_rst_busy", int'(busy_a), 0);
        chk("t5_rst_frame_done", int'(fd_a), 0);
        repeat (3) @(negedge clk);
        rst_a = 1'b1;
        q_a.push_back(8'h3C);
        send_a(8'h3C, 1'b0, c0);
        ifa.tvalid = 1'b0;
        repeat (50) @(negedge clk);
        chk("t5_queue_empty", q_a.size(), 0);

        // 4) STOP_BITS=2, gap 3: 0xFF last, then 0x81 held
        ifb.tdata = 8'hFF;
        ifb.tlast = 1'b1;
        ifb.tvalid = 1'b1;
        for (k = 0; k < 200 && ifb.tready !== 1'b1; k++) @(negedge clk);
        if (k == 200) chk("t4_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        ifb.tdata = 8'h81;
        ifb.tlast = 1'b0;
        lo = 0; hi = 0; fdc = -1; nst = -1; seen = 1'b0;
        for (int i = 0; i < 70; i++) begin
            if (i > 0) @(negedge clk);
            if (seen) ifb.tvalid = 1'b0;
            if (ifb.tvalid && ifb.tready === 1'b1) seen = 1'b1;
            if (i < 4 && tx_b === 1'b0) lo++;
            if (i >= 4 && i < 56 && tx_b === 1'b1) hi++;
            if (fd_b === 1'b1 && fdc < 0) fdc = i;
            if (i >= 4 && tx_b === 1'b0 && nst < 0) nst = i;
        end
        ifb.tvalid = 1'b0;
        chk("t4_low_cycles", lo, 4);
        chk("t4_high_cycles", hi, 52);
        chk("t4_fd_offset", fdc, 56);
        chk("t4_next_start", nst, 57);
        repeat (60) @(negedge clk);

        // 6) CLKS_PER_BIT=868, 0x0A run lengths at tx edges
        ifc.tdata = 8'h0A;
        ifc.tvalid = 1'b1;
        for (k = 0; k < 200 && ifc.tready !== 1'b1; k++) @(negedge clk);
        if (k == 200) chk("t6_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        ifc.tvalid = 1'b0;
        lvl = 0;
        len = 0;
        for (int i = 0; i < 9000 && runs.size() < 5; i++) begin
            if (i > 0) @(negedge clk);
            if (int'(tx_c) == lvl) begin
                len++;
            end else begin
                runs.push_back(len);
                lvl = int'(tx_c);
                len = 1;
            end
        end
        chk("t6_runs_seen", runs.size(), 5);
        for (int r = 0; r < 5 && r < runs.size(); r++)
            chk($sformatf("t6_run_%0d", r), runs[r], exp6[r]);

        chk("final_queue_empty", q_a.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
